count_monitor: RTL

- Receive-side checker for the free-running modulo-2^WIDTH up-counter stream produced by the team's counter FSM.
- Samples the count on `valid` and locks once the stream increments consistently.
- Flags every skipped or repeated value, counts errors, and drops lock after repeated failures.
- Sits downstream of the counter in lesson/test designs as its verifying consumer.

---
 rtl/count_monitor_pkg.sv | 27 ++
 rtl/count_monitor_if.sv | 42 ++++
 rtl/sat_counter.sv | 26 ++
 rtl/count_monitor.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/count_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_monitor_pkg
// Description : Shared constants for the count-stream monitor: state encoding,
//               default parameter values and a small sizing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package count_monitor_pkg;

    // Monitor state encoding; bit 1 set means the monitor reports lock
    localparam logic [1:0] HUNT    = 2'd0;
    localparam logic [1:0] CONFIRM = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;
    localparam logic [1:0] SLIP    = 2'd3;

    localparam int DEF_WIDTH        = 3;
    localparam int DEF_LOCK_COUNT   = 4;
    localparam int DEF_UNLOCK_COUNT = 2;
    localparam int DEF_ERR_W        = 8;

    // Larger of two integers, used to size the shared run counters
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/count_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : count_monitor_if
// Description : Count stream in, lock/error status out. The master side
//               produces the stream and observes status; the slave side is
//               the monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface count_monitor_if
    import count_monitor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ERR_W = DEF_ERR_W
) ();

    logic             valid;
    logic [WIDTH-1:0] count_in;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] expected;

    modport master (
        output valid,
        output count_in,
        input  locked,
        input  err_pulse,
        input  err_count,
        input  expected
    );

    modport slave (
        input  valid,
        input  count_in,
        output locked,
        output err_pulse,
        output err_count,
        output expected
    );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         inc,
    output logic [W-1:0]      q
);

    // Count up on inc, hold once every bit is set
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/count_monitor.sv
`default_nettype none
// ============================================================================
// Module      : count_monitor
// Description : Receive-side checker for a free-running modulo-2^WIDTH
//               up-counter. Locks after LOCK_COUNT consecutive increments,
//               flags every skipped/repeated value while locked, counts
//               errors (saturating) and drops lock after UNLOCK_COUNT
//               consecutive mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int LOCK_COUNT   = DEF_LOCK_COUNT,
    parameter int UNLOCK_COUNT = DEF_UNLOCK_COUNT,
    parameter int ERR_W        = DEF_ERR_W
) (
    input  wire logic       clk,
    input  wire logic       rst,
    count_monitor_if.slave  bus
);

    localparam int CNT_W = $clog2(max_int(LOCK_COUNT, UNLOCK_COUNT) + 1);
    localparam logic [CNT_W-1:0] c_LOCK_N   = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] c_UNLOCK_N = CNT_W'(UNLOCK_COUNT);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_good;
    logic [CNT_W-1:0] r_bad;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_expected;
    logic             r_err_pulse;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_good_nxt;
    logic [CNT_W-1:0] w_bad_nxt;
    logic [WIDTH-1:0] w_prev_inc;
    logic [CNT_W-1:0] w_good_inc;
    logic [CNT_W-1:0] w_bad_inc;
    logic             w_match;
    logic             w_err;
    logic [ERR_W-1:0] w_err_count;

    assign w_prev_inc = r_prev + 1'b1;
    assign w_good_inc = r_good + 1'b1;
    assign w_bad_inc  = r_bad + 1'b1;
    // Natural wrap of w_prev_inc makes max -> 0 a legal increment
    assign w_match    = (bus.count_in == w_prev_inc);

    // Next-state, run counters and error decision for the current sample
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_bad_nxt   = r_bad;
        w_err       = 1'b0;
        if (bus.valid) begin
            case (r_state)
                HUNT: begin
                    w_state_nxt = CONFIRM;
                    w_good_nxt  = '0;
                    w_bad_nxt   = '0;
                end
                CONFIRM: begin
                    if (w_match) begin
                        if (w_good_inc == c_LOCK_N) begin
                            w_state_nxt = LOCKED;
                            w_good_nxt  = '0;
                        end else begin
                            w_good_nxt  = w_good_inc;
                        end
                    end else begin
                        // No error before lock; just restart the run
                        w_good_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (!w_match) begin
                        w_err = 1'b1;
                        if (UNLOCK_COUNT == 1) begin
                            w_state_nxt = HUNT;
                            w_bad_nxt   = '0;
                        end else begin
                            w_state_nxt = SLIP;
                            w_bad_nxt   = CNT_W'(1);
                        end
                    end
                end
                SLIP: begin
                    if (w_match) begin
                        w_state_nxt = LOCKED;
                        w_bad_nxt   = '0;
                    end else begin
                        w_err = 1'b1;
                        if (w_bad_inc == c_UNLOCK_N) begin
                            w_state_nxt = HUNT;
                            w_bad_nxt   = '0;
                        end else begin
                            w_bad_nxt   = w_bad_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_good_nxt  = '0;
                    w_bad_nxt   = '0;
                end
            endcase
        end
    end

    // State, history and registered status; every sample rebases prev
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_good      <= '0;
            r_bad       <= '0;
            r_prev      <= '0;
            r_expected  <= WIDTH'(1);
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_good      <= w_good_nxt;
            r_bad       <= w_bad_nxt;
            r_err_pulse <= w_err;
            if (bus.valid) begin
                r_prev     <= bus.count_in;
                r_expected <= bus.count_in + 1'b1;
            end
        end
    end

    sat_counter #(
        .W   (ERR_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_err),
        .q   (w_err_count)
    );

    // LOCKED and SLIP both report lock (state bit 1)
    assign bus.locked    = r_state[1];
    assign bus.err_pulse = r_err_pulse;
    assign bus.err_count = w_err_count;
    assign bus.expected  = r_expected;

endmodule
`default_nettype wire
